// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD constants, converter state encoding and width helper
package bcd_pkg;
   localparam int BCD_W = 4;
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CONV = 2'd1, ST_DONE = 2'd2} state_t;
   function automatic int min_bin_w(input int n);
      int v;
      v = 1;
      for (int i = 0; i < n; i++) v = v * 10;
      return $clog2(v);
   endfunction
endpackage

// File: rtl/bcd_mul10_add.sv
// bcd_mul10_add: combinational acc*10 + digit, invalid digits add 0 and raise bad
module bcd_mul10_add
   import bcd_pkg::*;
#(
   parameter int BIN_W = 14
) (
   input  logic [BIN_W-1:0] acc,
   input  logic [BCD_W-1:0] digit,
   output logic [BIN_W-1:0] nxt,
   output logic             bad
);
   assign bad = digit > BCD_MAX;
   assign nxt = BIN_W'(({4'b0, acc} << 3) + ({4'b0, acc} << 1) + {{BIN_W{1'b0}}, bad ? 4'd0 : digit});
endmodule

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential BCD-to-binary, one digit per clock, MSB first; optional BCD_TO_BIN_SKIP_LZ_EN skips leading zero digits
module bcd_to_bin_seq
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [BCD_W*DIGITS-1:0] bcd_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [BIN_W-1:0]      bin_out,
   output logic                  flag
);
   localparam int W  = BCD_W * DIGITS;
   localparam int CW = $clog2(DIGITS + 1);
   state_t state, nxt_state;
   logic [W-1:0] sreg, load_sreg;
   logic [BIN_W-1:0] acc, acc_nxt;
   logic [CW-1:0] cnt, load_cnt;
   logic bad;
   if (DIGITS < 1 || DIGITS > 8 || BIN_W < min_bin_w(DIGITS)) begin : g_bad_param
      $error("bcd_to_bin_seq: DIGITS must be 1..8 and BIN_W must hold 10^DIGITS-1");
   end
   bcd_mul10_add #(.BIN_W(BIN_W)) u_mac (
      .acc  (acc),
      .digit(sreg[W-1 -: BCD_W]),
      .nxt  (acc_nxt),
      .bad  (bad)
   );
`ifdef BCD_TO_BIN_SKIP_LZ_EN
   logic [CW-1:0] lz;
   logic stop;
   // count leading zero digits above the lowest one, so at least one digit is always converted
   always_comb begin
      lz = '0;
      stop = 1'b0;
      for (int i = DIGITS - 1; i > 0; i--) begin
         if (!stop && bcd_in[BCD_W*i +: BCD_W] == '0) lz = lz + 1'b1;
         else stop = 1'b1;
      end
   end
   assign load_sreg = bcd_in << (BCD_W * lz);
   assign load_cnt  = CW'(DIGITS) - lz;
`else
   assign load_sreg = bcd_in;
   assign load_cnt  = CW'(DIGITS);
`endif
   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else state <= nxt_state;
   end
   // next state and handshake outputs
   always_comb begin
      in_ready  = state == ST_IDLE;
      out_valid = state == ST_DONE;
      nxt_state = (state == ST_IDLE && in_valid)     ? ST_CONV :
                  (state == ST_CONV && cnt == CW'(1)) ? ST_DONE :
                  (state == ST_DONE && out_ready)    ? ST_IDLE : state;
   end
   // capture on accept, then one multiply-by-10-and-add step per CONV cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg    <= '0;
         acc     <= '0;
         cnt     <= '0;
         flag    <= 1'b0;
         bin_out <= '0;
      end else if (in_ready && in_valid) begin
         sreg <= load_sreg;
         acc  <= '0;
         cnt  <= load_cnt;
         flag <= 1'b0;
      end else if (state == ST_CONV) begin
         sreg <= sreg << BCD_W;
         acc  <= acc_nxt;
         cnt  <= cnt - 1'b1;
         flag <= flag | bad;
         if (cnt == CW'(1)) bin_out <= acc_nxt;
      end
   end
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: scoreboard bench for bcd_to_bin_seq (4-digit and 1-digit instances)
module tb_bcd_to_bin_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0, out_ready = 1'b1;
   logic in_ready, out_valid, flag;
   logic [15:0] bcd_in = '0;
   logic [13:0] bin_out;
   logic iv1 = 1'b0;
   logic ir1, ov1, fl1;
   logic [3:0] bcd1 = '0, bo1;
   logic [14:0] q0[$];
   logic [4:0] q1[$];
   int n_cmp = 0, n_err = 0;
   always #5 clk = ~clk;
   bcd_to_bin_seq #(.DIGITS(4), .BIN_W(14)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .bcd_in(bcd_in),
      .out_valid(out_valid), .out_ready(out_ready), .bin_out(bin_out), .flag(flag)
   );
   bcd_to_bin_seq #(.DIGITS(1), .BIN_W(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .bcd_in(bcd1),
      .out_valid(ov1), .out_ready(1'b1), .bin_out(bo1), .flag(fl1)
   );
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask
   // monitor for the 4-digit instance
   always @(negedge clk) begin
      logic [14:0] e;
      if (rst_n && out_valid && out_ready) begin
         if (q0.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL mon0: unexpected output bin=%0d flag=%0b", bin_out, flag);
         end else begin
            e = q0.pop_front();
            check("mon0_bin", bin_out, e[13:0]);
            check("mon0_flag", flag, e[14]);
         end
      end
   end
   // monitor for the 1-digit instance
   always @(negedge clk) begin
      logic [4:0] e;
      if (rst_n && ov1) begin
         if (q1.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL mon1: unexpected output bin=%0d flag=%0b", bo1, fl1);
         end else begin
            e = q1.pop_front();
            check("mon1_bin", bo1, e[3:0]);
            check("mon1_flag", fl1, e[4]);
         end
      end
   end
   task automatic wait_ready();
      int c = 0;
      while (!in_ready && c < 20) begin
         @(posedge clk); #1; c++;
      end
      check("in_ready", in_ready, 1);
   endtask
   task automatic send(input logic [15:0] w, input logic [13:0] b, input logic f, input int lat_def, input int lat_lz);
      int c = 0;
      int lat;
`ifdef BCD_TO_BIN_SKIP_LZ_EN
      lat = lat_lz;
`else
      lat = lat_def;
`endif
      wait_ready();
      q0.push_back({f, b});
      in_valid = 1'b1;
      bcd_in = w;
      @(posedge clk); #1;
      in_valid = 1'b0;
      while (!out_valid && c < 20) begin
         @(posedge clk); #1; c++;
      end
      check("latency", c, lat);
   endtask
   initial begin
      int seen;
      int c;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_bin_out", bin_out, 0);
      check("rst_flag", flag, 0);
      rst_n = 1'b1;
      send(16'h9999, 14'd9999, 1'b0, 4, 4);
      send(16'h0000, 14'd0,    1'b0, 4, 1);
      send(16'h1A23, 14'd1023, 1'b1, 4, 4);
      send(16'h0042, 14'd42,   1'b0, 4, 2);
      send(16'h1234, 14'd1234, 1'b0, 4, 4);
      send(16'h0007, 14'd7,    1'b0, 4, 1);
      send(16'h0A00, 14'd0,    1'b1, 4, 3);
      send(16'hF000, 14'd0,    1'b1, 4, 4);
      send(16'h0905, 14'd905,  1'b0, 4, 3);
      send(16'h8765, 14'd8765, 1'b0, 4, 4);
      wait_ready();
      in_valid = 1'b1;
      bcd_in = 16'h4321;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", out_valid, 0);
      check("abort_bin_out", bin_out, 0);
      check("abort_flag", flag, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      check("abort_in_ready", in_ready, 1);
      seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         seen = seen | int'(out_valid);
      end
      check("abort_no_output", seen, 0);
      out_ready = 1'b0;
      send(16'h2018, 14'd2018, 1'b0, 4, 4);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         bcd_in = 16'h5555;
         check("bp_bin_out", bin_out, 2018);
         check("bp_flag", flag, 0);
         check("bp_in_ready", in_ready, 0);
         check("bp_out_valid", out_valid, 1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_ready", in_ready, 1);
      check("bp_release_valid", out_valid, 0);
      send(16'h0000, 14'd0, 1'b0, 4, 1);
      for (int v = 0; v < 16; v++) begin
         c = 0;
         while (!ir1 && c < 20) begin
            @(posedge clk); #1; c++;
         end
         check("d1_ready", ir1, 1);
         q1.push_back({v > 9, v > 9 ? 4'd0 : 4'(v)});
         iv1 = 1'b1;
         bcd1 = 4'(v);
         @(posedge clk); #1;
         iv1 = 1'b0;
         c = 0;
         while (!ov1 && c < 20) begin
            @(posedge clk); #1; c++;
         end
         check("d1_latency", c, 1);
      end
      repeat (4) @(posedge clk);
      #1;
      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
- Sequential BCD-to-binary converter: the reverse path of the team's BCD adder datapath.
- Accepts a packed word of BCD digits and produces its binary value plus an invalid-digit flag.
- Processes one digit per clock, MSB digit first, by multiply-by-10-and-add.
- Sits between BCD arithmetic blocks and binary consumers; valid/ready handshake on both sides.

Parameters:
- DIGITS, 4: number of BCD digits in the input word (legal range 1..8).
- BIN_W, 14: binary output width; must hold 10^DIGITS-1 (14 bits for 4 digits).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  bcd_in is valid.
- in_ready  output  1  block can accept a word (high only in IDLE).
- bcd_in  input  4*DIGITS  packed digits; [4*DIGITS-1 -: 4] is the most significant digit.
- out_valid  output  1  bin_out/flag are valid; held until accepted.
- out_ready  input  1  consumer accepts the result.
- bin_out  output  BIN_W  converted value.
- flag  output  1  at least one input digit was greater than 9.

Behaviour:
- Reset is asynchronous on rst_n low; all state clears immediately: state=IDLE, in_ready=1 after release, out_valid=0, bin_out=0, flag=0, accumulator=0, digit counter=0.
- Reset mid-conversion aborts the conversion and discards it; no output is produced.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, capture bcd_in into a shift register, clear acc and flag, set cnt=DIGITS, go to CONV.
  - CONV: in_ready=0. Each cycle d = top digit; acc <= acc*10 + (d<=9 ? d : 0); flag <= flag | (d>9); shift left 4; cnt--. After the cycle with cnt==1, go to DONE.
  - DONE: out_valid=1, bin_out=acc, flag stable. On out_ready, go to IDLE. While out_ready is low, hold all outputs unchanged.
- Arithmetic: acc*10 = (acc<<3)+(acc<<1), evaluated in BIN_W+4 bits and truncated to BIN_W. With legal parameters there is no overflow.
- Invalid digits (10..15) contribute 0 and set flag. Example: 0x1A23 gives bin_out=1023, flag=1.
- Latency: accept at edge T; out_valid rises after edge T+DIGITS; earliest next accept at edge T+DIGITS+2 (no same-cycle bypass from DONE to accept).
- in_valid while in_ready=0 is ignored; the word is not captured.
- bin_out keeps its last value outside DONE; it is only meaningful while out_valid=1.

Optional Feature:
- Macro: BCD_TO_BIN_SKIP_LZ_EN.
- Defined: at accept, leading zero digits are counted combinationally. The shift register is pre-shifted past them and cnt = DIGITS - lz, with a minimum of 1 (all-zero input takes 1 cycle). Latency becomes max(1, DIGITS-lz) CONV cycles. A leading invalid digit is not a zero and is not skipped.
- Undefined: fixed latency of DIGITS CONV cycles; no leading-zero logic.

Decomposition:
- Shared package bcd_pkg:
  - BCD_W=4, BCD_MAX=9.
  - State encoding constants ST_IDLE, ST_CONV, ST_DONE.
  - Function for the minimum binary width for N digits, used to check BIN_W.
- One natural sub-module, bcd_mul10_add: combinational acc*10 + digit with digit validity check; outputs next acc and an invalid bit.

Test Plan:
- Reset: assert rst_n=0 mid-CONV on input 0x4321 -> outputs clear immediately; after release in_ready=1, out_valid never asserts for that word.
- Basic: bcd_in=0x9999, out_ready=1 -> out_valid after 4 CONV cycles, bin_out=9999, flag=0; then 0x0000 -> bin_out=0, flag=0.
- Invalid digit: bcd_in=0x1A23 -> bin_out=1023, flag=1; next word 0x0042 -> flag=0, bin_out=42 (flag does not stick across words).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid on 0x2018 -> bin_out=2018 and flag held stable, in_ready=0 throughout, in_valid pulses ignored; out_ready=1 -> IDLE the next cycle.
- Exhaustive single digit with DIGITS=1, BIN_W=4: inputs 0..15 -> bin_out=value for 0..9 with flag=0; bin_out=0 with flag=1 for 10..15.
- With BCD_TO_BIN_SKIP_LZ_EN defined: 0x0007 -> 1 CONV cycle, bin_out=7; 0x0000 -> 1 cycle; 0x0A00 -> 3 cycles, flag=1, bin_out=0.
